// File: rtl/arrange_pkg.sv
// Shared types and helpers for the odd/even arrange stream controller.
package arrange_pkg;

    // Default frame geometry; the top-level parameters default to these.
    localparam int N_DEF = 10;
    localparam int W_DEF = 4;
    localparam int PW    = $clog2(N_DEF);
    localparam int CW    = $clog2(N_DEF + 1);

    // Controller phases: collecting a frame, replaying evens, replaying odds.
    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        EMIT_EVEN = 2'd1,
        EMIT_ODD  = 2'd2
    } state_t;

    // Parity of an element is carried entirely by its least significant bit.
    function automatic logic is_odd(input logic [W_DEF-1:0] x);
        return x[0];
    endfunction

endpackage

// File: rtl/arrange_frame_buf.sv
// Frame storage: N x W register file, one write port, one asynchronous read
// port, all entries cleared by reset.
module arrange_frame_buf #(
    parameter int N  = 10,
    parameter int W  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [N-1:0][W-1:0] w_mem;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic [W-1:0] r_entry;

            // Each entry captures the write data only when it is addressed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
                    r_entry <= i_wr_data;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    // Read is combinational so the controller sees the addressed entry in
    // the same cycle the read pointer points at it.
    assign o_rd_data = w_mem[i_rd_addr];

endmodule

// File: rtl/arrange_stream_ctrl.sv
// Collects a frame of N elements from a valid/ready stream, then replays it
// as all even elements followed by all odd elements, each in arrival order.
module arrange_stream_ctrl
    import arrange_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_odd,
    output logic                     out_last,
    output logic [$clog2(N+1)-1:0]   even_count,
    output logic                     busy
);

    localparam int AW  = $clog2(N);
    localparam int CNW = $clog2(N + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_emit_cnt;
    logic [CNW-1:0]  r_even_count;

    logic            w_wr_en;
    logic            w_emit;
    logic            w_match;
    logic            w_out_fire;
    logic            w_advance;
    logic [W-1:0]    w_rd_data;

    arrange_frame_buf #(
        .N  (N),
        .W  (W),
        .AW (AW)
    ) u_frame_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Input is only accepted while loading; during replay the producer is
    // simply held off, so nothing offered then is lost.
    assign w_wr_en    = (r_state == LOAD) & in_valid;
    assign w_emit     = (r_state != LOAD);
    // An entry belongs to the current pass when its parity equals the pass.
    assign w_match    = (is_odd(w_rd_data) == (r_state == EMIT_ODD));
    assign w_out_fire = w_emit & w_match & out_ready;
    // Non-matching entries are skipped in a single cycle; matching ones wait
    // for the consumer.
    assign w_advance  = w_emit & (~w_match | out_ready);

    assign in_ready   = (r_state == LOAD);
    assign busy       = w_emit;
    assign out_valid  = w_emit & w_match;
    assign out_data   = w_emit ? w_rd_data : '0;
    assign out_odd    = (r_state == EMIT_ODD);
    assign out_last   = out_valid & (r_emit_cnt == LAST_IDX);
    assign even_count = r_even_count;

    // Phase sequencing, buffer pointers and the output transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_emit_cnt <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        if (r_wr_ptr == LAST_IDX) begin
                            r_state    <= EMIT_EVEN;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_emit_cnt <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                    end
                end
                EMIT_EVEN, EMIT_ODD: begin
                    // Saturate so the counter never wraps past the last slot.
                    if (w_out_fire && (r_emit_cnt != LAST_IDX)) begin
                        r_emit_cnt <= r_emit_cnt + AW'(1);
                    end
                    if (w_advance) begin
                        if (r_rd_ptr == LAST_IDX) begin
                            r_rd_ptr <= '0;
                            r_state  <= (r_state == EMIT_EVEN) ? EMIT_ODD : LOAD;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Even tally restarts on the first element of a frame and then counts
    // every accepted element with a clear LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_even_count <= '0;
        end else if (w_wr_en) begin
            if (r_wr_ptr == '0) begin
                r_even_count <= is_odd(in_data) ? CNW'(0) : CNW'(1);
            end else if (!is_odd(in_data)) begin
                r_even_count <= r_even_count + CNW'(1);
            end
        end
    end

endmodule
